// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC/NPC pair with branch-delay-slot advance, imem req/ack
// handshake, one-word hold buffer for decode stalls, and the IF/ID pipeline register.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  pc_source_select,
  input  logic [31:0] branch_target,
  input  logic        stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] npc_out,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  localparam logic [31:0] PC_INIT  = {RESET_PC[31:2], 2'b00};
  localparam logic [31:0] NPC_INIT = PC_INIT + 32'd4;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] npc;
  logic [31:0] hold_buf;

  logic        word_arrives;
  logic        leave_hold;
  logic        advance;
  logic [31:0] deliver_word;
  logic [31:0] next_npc;
  logic        unused_target_bits;

  assign unused_target_bits = ^branch_target[1:0];

  // A flush counts as consuming the word: the PC still moves past it.
  always_comb begin
    word_arrives = (state == S_REQ) && imem_ack;
    leave_hold   = (state == S_HOLD) && (!stall || flush);
    advance      = (word_arrives && (!stall || flush)) || leave_hold;
    deliver_word = (state == S_HOLD) ? hold_buf : imem_rdata;
    next_npc     = (pc_source_select != 2'b00) ? {branch_target[31:2], 2'b00}
                                               : npc + 32'd4;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      pc          <= PC_INIT;
      npc         <= NPC_INIT;
      hold_buf    <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (word_arrives && stall && !flush) begin
            hold_buf <= imem_rdata;
            state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (leave_hold) begin
            state <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (advance) begin
        pc  <= npc;
        npc <= next_npc;
      end

      // Flush wins over delivery; a missing ack without stall inserts a bubble.
      if (flush) begin
        if_id_instr <= NOP_INSTR;
        if_id_pc    <= '0;
        if_id_valid <= 1'b0;
      end else if (advance) begin
        if_id_instr <= deliver_word;
        if_id_pc    <= pc;
        if_id_valid <= 1'b1;
      end else if ((state == S_REQ) && !imem_ack && !stall) begin
        if_id_instr <= NOP_INSTR;
        if_id_valid <= 1'b0;
      end
    end
  end

  assign imem_req  = (state == S_REQ);
  assign imem_addr = {pc[31:2], 2'b00};
  assign pc_out    = pc;
  assign npc_out   = npc;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level fetch model.
module tb_if_fetch_stage;

  logic        clk;
  logic        reset;
  logic [1:0]  pc_source_select;
  logic [31:0] branch_target;
  logic        stall;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] npc_out;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;

  int checks = 0;
  int passes = 0;
  bit check_en = 0;

  // Model: "started" means the first request has been issued; a non-empty
  // held queue means a word is parked waiting for decode.
  bit          m_started;
  logic [31:0] held[$];
  logic [31:0] m_pc, m_npc;
  logic [31:0] m_instr, m_ifpc;
  bit          m_valid, m_ifpc_known;

  if_fetch_stage dut (
    .clk(clk), .reset(reset),
    .pc_source_select(pc_source_select), .branch_target(branch_target),
    .stall(stall), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc_out(pc_out), .npc_out(npc_out),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic checkOutput();
    checkVal("imem_req", {31'd0, imem_req}, {31'd0, m_started && held.size() == 0});
    checkVal("imem_addr", imem_addr, m_pc);
    checkVal("pc_out", pc_out, m_pc);
    checkVal("npc_out", npc_out, m_npc);
    checkVal("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
    checkVal("if_id_instr", if_id_instr, m_instr);
    if (m_ifpc_known) checkVal("if_id_pc", if_id_pc, m_ifpc);
  endtask

  always @(negedge clk) if (check_en) checkOutput();

  task automatic modelReset();
    m_started = 0;
    held.delete();
    m_pc = 32'h0; m_npc = 32'h4;
    m_instr = 32'h0; m_ifpc = 32'h0; m_valid = 0; m_ifpc_known = 1;
  endtask

  // Predict the effect of the coming clock edge from the inputs just driven.
  task automatic modelStep();
    bit holding, got, deliver;
    logic [31:0] word;
    holding = held.size() != 0;
    got     = m_started && !holding && imem_ack;
    deliver = (got || holding) && (!stall || flush);
    word    = holding ? held[0] : imem_rdata;
    if (flush) begin
      m_instr = 32'h0; m_ifpc = 32'h0; m_valid = 0; m_ifpc_known = 1;
    end else if (deliver) begin
      m_instr = word; m_ifpc = m_pc; m_valid = 1; m_ifpc_known = 1;
    end else if (m_started && !holding && !imem_ack && !stall) begin
      m_instr = 32'h0; m_valid = 0; m_ifpc_known = 0;
    end
    if (deliver) begin
      if (holding) void'(held.pop_front());
      m_pc  = m_npc;
      m_npc = (pc_source_select != 2'b00) ? (branch_target & 32'hFFFF_FFFC) : m_npc + 32'd4;
    end else if (got) begin
      held.push_back(imem_rdata);
    end
    m_started = 1;
  endtask

  task automatic applyStimulus(input bit ack, input bit stl, input bit fl,
                               input logic [1:0] sel, input logic [31:0] tgt,
                               input logic [31:0] rd);
    @(negedge clk); #1;
    reset = 1; imem_ack = ack; stall = stl; flush = fl;
    pc_source_select = sel; branch_target = tgt; imem_rdata = rd;
    modelStep();
  endtask

  task automatic afterEdge();
    @(posedge clk); #2;
  endtask

  // Reset is asserted between edges; outputs must change without a clock.
  task automatic doReset();
    @(negedge clk); #3;
    reset = 0;
    #1;
    checkVal("rst imem_req", {31'd0, imem_req}, 32'd0);
    checkVal("rst pc_out", pc_out, 32'h0);
    checkVal("rst npc_out", npc_out, 32'h4);
    checkVal("rst if_id_valid", {31'd0, if_id_valid}, 32'd0);
    checkVal("rst if_id_instr", if_id_instr, 32'h0);
    checkVal("rst if_id_pc", if_id_pc, 32'h0);
    modelReset();
  endtask

  task automatic ackWord(input logic [31:0] rd);
    applyStimulus(1, 0, 0, 2'b00, 32'h0, rd);
  endtask

  initial begin
    reset = 0; imem_ack = 0; stall = 0; flush = 0;
    pc_source_select = 0; branch_target = 0; imem_rdata = 0;
    modelReset();
    #1 check_en = 1;

    // Run 1: sequential fetch, delay-slot redirect, stall/hold, withheld ack.
    applyStimulus(0, 0, 0, 2'b00, 0, 0); afterEdge();
    checkVal("first req", {31'd0, imem_req}, 32'd1);
    ackWord(32'h1000_0000); afterEdge();
    checkVal("seq pc0", if_id_pc, 32'h0);
    checkVal("seq instr0", if_id_instr, 32'h1000_0000);
    ackWord(32'h1000_0001); afterEdge();
    checkVal("seq pc4", if_id_pc, 32'h4);
    applyStimulus(1, 0, 0, 2'b01, 32'h40, 32'h1000_0002); afterEdge();
    checkVal("br pc8", if_id_pc, 32'h8);
    checkVal("br npc", npc_out, 32'h40);
    ackWord(32'h1000_0003); afterEdge();
    checkVal("delay slot", if_id_pc, 32'hC);
    ackWord(32'h1000_0004); afterEdge();
    checkVal("target", if_id_pc, 32'h40);
    ackWord(32'h1000_0005); afterEdge();
    checkVal("target+4", if_id_pc, 32'h44);
    applyStimulus(1, 1, 0, 2'b00, 0, 32'hABCD_0001); afterEdge();
    checkVal("hold req", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 1, 0, 2'b00, 0, 32'hDEAD_BEEF); afterEdge();
      checkVal("hold ifpc", if_id_pc, 32'h44);
      checkVal("hold instr", if_id_instr, 32'h1000_0005);
    end
    applyStimulus(0, 0, 0, 2'b00, 0, 0); afterEdge();
    checkVal("unhold instr", if_id_instr, 32'hABCD_0001);
    checkVal("unhold pc", if_id_pc, 32'h48);
    checkVal("unhold pc_out", pc_out, 32'h4C);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 2'b00, 0, 32'h5555_5555); afterEdge();
      checkVal("bubble valid", {31'd0, if_id_valid}, 32'd0);
      checkVal("bubble pc_out", pc_out, 32'h4C);
    end
    ackWord(32'h2000_0000); afterEdge();
    checkVal("after bubble", if_id_pc, 32'h4C);
    doReset();

    // Run 2: flush with ack, flush in hold, NPC wrap, reset in hold.
    applyStimulus(0, 0, 0, 2'b00, 0, 0);
    for (int k = 0; k < 4; k++) ackWord(32'h3000_0000 + k);
    applyStimulus(1, 0, 1, 2'b00, 0, 32'h3000_0004); afterEdge();
    checkVal("flush valid", {31'd0, if_id_valid}, 32'd0);
    checkVal("flush pc_out", pc_out, 32'h14);
    ackWord(32'h3000_0005); afterEdge();
    checkVal("post flush", if_id_pc, 32'h14);
    applyStimulus(1, 1, 0, 2'b00, 0, 32'h3000_0006);
    applyStimulus(0, 1, 1, 2'b00, 0, 0); afterEdge();
    checkVal("hold flush req", {31'd0, imem_req}, 32'd1);
    checkVal("hold flush pc", pc_out, 32'h1C);
    ackWord(32'h3000_0007); afterEdge();
    checkVal("after hold flush", if_id_pc, 32'h1C);
    applyStimulus(1, 0, 0, 2'b11, 32'hFFFF_FFFB, 32'h4000_0000);
    ackWord(32'h4000_0001);
    ackWord(32'h4000_0002); afterEdge();
    checkVal("wrap npc", npc_out, 32'h0);
    ackWord(32'h4000_0003); afterEdge();
    checkVal("wrap ifpc", if_id_pc, 32'hFFFF_FFFC);
    checkVal("wrap pc", pc_out, 32'h0);
    applyStimulus(1, 1, 0, 2'b00, 0, 32'h4000_0004);
    doReset();

    // Run 3: randomized traffic against the model.
    applyStimulus(0, 0, 0, 2'b00, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      logic [1:0]  sel;
      logic [31:0] tgt;
      sel = ($urandom_range(0, 99) < 15) ? 2'($urandom_range(1, 3)) : 2'b00;
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : $urandom;
      applyStimulus($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 25,
                    $urandom_range(0, 99) < 8, sel, tgt, $urandom);
    end
    @(negedge clk); #1;
    check_en = 0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
